// File: rtl/pipe_ctrl_unit_if.sv
// rtl/pipe_ctrl_unit_if.sv - control-unit port bundle between ID-stage datapath and pipe_ctrl_unit
//
// Purpose: groups the opcode/register-field inputs and the hazard/control outputs
// of pipe_ctrl_unit so the datapath and the control unit connect through one port.
//
// Signals (direction as seen by the control unit, modport slave):
//   Op_i, IFID_Rs_i, IFID_Rt_i, IDEX_Rt_i, IDEX_Rd_i, Equal_i    in
//   PCWrite_o, IFIDWrite_o, IFFlush_o, PCSrc_o                    out  fetch/PC control
//   EX_RegDst_o, EX_ALUSrc_o, EX_ALUOp_o, EX_MemRead_o,
//   EX_RegWrite_o                                                 out  ID/EX copies
//   MEM_MemRead_o, MEM_MemWrite_o, MEM_RegWrite_o                 out  EX/MEM copies
//   WB_RegWrite_o, WB_MemtoReg_o                                  out  MEM/WB copies
// The master modport is the datapath side (drives the inputs, observes the outputs).

interface pipe_ctrl_unit_if #(
    parameter int ADDR_W = 5
) ();
    logic [5:0]        Op_i;
    logic [ADDR_W-1:0] IFID_Rs_i;
    logic [ADDR_W-1:0] IFID_Rt_i;
    logic [ADDR_W-1:0] IDEX_Rt_i;
    logic [ADDR_W-1:0] IDEX_Rd_i;
    logic              Equal_i;

    logic              PCWrite_o;
    logic              IFIDWrite_o;
    logic              IFFlush_o;
    logic [1:0]        PCSrc_o;
    logic              EX_RegDst_o;
    logic              EX_ALUSrc_o;
    logic [1:0]        EX_ALUOp_o;
    logic              EX_MemRead_o;
    logic              EX_RegWrite_o;
    logic              MEM_MemRead_o;
    logic              MEM_MemWrite_o;
    logic              MEM_RegWrite_o;
    logic              WB_RegWrite_o;
    logic              WB_MemtoReg_o;

    modport slave (
        input  Op_i, IFID_Rs_i, IFID_Rt_i, IDEX_Rt_i, IDEX_Rd_i, Equal_i,
        output PCWrite_o, IFIDWrite_o, IFFlush_o, PCSrc_o,
        output EX_RegDst_o, EX_ALUSrc_o, EX_ALUOp_o, EX_MemRead_o, EX_RegWrite_o,
        output MEM_MemRead_o, MEM_MemWrite_o, MEM_RegWrite_o,
        output WB_RegWrite_o, WB_MemtoReg_o
    );

    modport master (
        output Op_i, IFID_Rs_i, IFID_Rt_i, IDEX_Rt_i, IDEX_Rd_i, Equal_i,
        input  PCWrite_o, IFIDWrite_o, IFFlush_o, PCSrc_o,
        input  EX_RegDst_o, EX_ALUSrc_o, EX_ALUOp_o, EX_MemRead_o, EX_RegWrite_o,
        input  MEM_MemRead_o, MEM_MemWrite_o, MEM_RegWrite_o,
        input  WB_RegWrite_o, WB_MemtoReg_o
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - pipelined MIPS main decoder with hazard stall and ID-stage branch/jump resolve
//
// Purpose: decodes the IF/ID opcode into a control bundle, carries it through
// ID/EX, EX/MEM and MEM/WB control registers, detects load-use and branch-operand
// hazards (stalling PC and IF/ID while bubbling ID/EX) and resolves beq/j in ID.
//
// Ports:
//   clk_i  in   core clock, rising edge
//   rst_i  in   synchronous active-high reset
//   bus    pipe_ctrl_unit_if.slave (opcode/register fields in, control out)
//
// Parameters:
//   ADDR_W      register-address width (must match the interface)
//   LOAD_STALL  bubble cycles per load-use hazard, 1..3
//
// Optional build macro CTRL_EXT_OPS_EN: adds bne (000101) and ori (001101).

module pipe_ctrl_unit #(
    parameter int ADDR_W     = 5,
    parameter int LOAD_STALL = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    pipe_ctrl_unit_if.slave bus
);
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;

    localparam logic [ADDR_W-1:0] REG_ZERO      = '0;
    localparam logic [1:0]        LOAD_CNT_INIT = 2'(LOAD_STALL - 1);

    ex_ctrl_t          dec_ctrl;
    logic              dec_branch;
    logic              dec_jump;
    logic              dec_bne;
    logic              uses_rs;
    logic              uses_rt;

    ex_ctrl_t          ex_q;
    mem_ctrl_t         mem_q;
    wb_ctrl_t          wb_q;
    logic [1:0]        cnt;

    logic [ADDR_W-1:0] ex_dest;
    logic              load_use;
    logic              br_haz;
    logic              stall;
    logic              br_taken;

    // ID-stage decode; unknown opcodes fall through to the all-zero bundle.
    always_comb begin
        dec_ctrl   = '0;
        dec_branch = 1'b0;
        dec_jump   = 1'b0;
        dec_bne    = 1'b0;
        uses_rs    = 1'b0;
        uses_rt    = 1'b0;
        case (bus.Op_i)
            6'b000000: begin
                dec_ctrl.reg_dst   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = 2'b10;
                uses_rs            = 1'b1;
                uses_rt            = 1'b1;
            end
            6'b001000: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                uses_rs            = 1'b1;
            end
            6'b100011: begin
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                uses_rs             = 1'b1;
            end
            6'b101011: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                uses_rs            = 1'b1;
                uses_rt            = 1'b1;
            end
            6'b000100: begin
                dec_ctrl.alu_op = 2'b01;
                dec_branch      = 1'b1;
                uses_rs         = 1'b1;
                uses_rt         = 1'b1;
            end
            6'b000010: begin
                dec_jump = 1'b1;
            end
`ifdef CTRL_EXT_OPS_EN
            6'b000101: begin
                dec_ctrl.alu_op = 2'b01;
                dec_branch      = 1'b1;
                dec_bne         = 1'b1;
                uses_rs         = 1'b1;
                uses_rt         = 1'b1;
            end
            6'b001101: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = 2'b11;
                uses_rs            = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Hazard detection and fetch control. A branch in ID compares register
    // values this cycle, so any producer still in EX must drain first.
    always_comb begin
        ex_dest  = ex_q.reg_dst ? bus.IDEX_Rd_i : bus.IDEX_Rt_i;
        load_use = ex_q.mem_read && (bus.IDEX_Rt_i != REG_ZERO) &&
                   ((uses_rs && (bus.IDEX_Rt_i == bus.IFID_Rs_i)) ||
                    (uses_rt && (bus.IDEX_Rt_i == bus.IFID_Rt_i)));
        br_haz   = dec_branch && ex_q.reg_write && (ex_dest != REG_ZERO) &&
                   ((ex_dest == bus.IFID_Rs_i) || (ex_dest == bus.IFID_Rt_i));
        stall    = load_use || br_haz || (cnt != 2'd0);
        br_taken = dec_branch && (dec_bne ? !bus.Equal_i : bus.Equal_i);

        bus.PCWrite_o   = !stall;
        bus.IFIDWrite_o = !stall;
        bus.IFFlush_o   = 1'b0;
        bus.PCSrc_o     = 2'b00;
        if (!stall) begin
            if (dec_jump) begin
                bus.PCSrc_o   = 2'b10;
                bus.IFFlush_o = 1'b1;
            end else if (br_taken) begin
                bus.PCSrc_o   = 2'b01;
                bus.IFFlush_o = 1'b1;
            end
        end
    end

    // cnt holds the extra bubbles still owed after the detecting cycle; the
    // back half of the pipe keeps advancing regardless of stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt   <= 2'd0;
        end else begin
            ex_q             <= stall ? '0 : dec_ctrl;
            mem_q.mem_to_reg <= ex_q.mem_to_reg;
            mem_q.reg_write  <= ex_q.reg_write;
            mem_q.mem_read   <= ex_q.mem_read;
            mem_q.mem_write  <= ex_q.mem_write;
            wb_q.mem_to_reg  <= mem_q.mem_to_reg;
            wb_q.reg_write   <= mem_q.reg_write;
            if (cnt != 2'd0) begin
                cnt <= cnt - 2'd1;
            end else if (load_use) begin
                cnt <= LOAD_CNT_INIT;
            end
        end
    end

    assign bus.EX_RegDst_o    = ex_q.reg_dst;
    assign bus.EX_ALUSrc_o    = ex_q.alu_src;
    assign bus.EX_ALUOp_o     = ex_q.alu_op;
    assign bus.EX_MemRead_o   = ex_q.mem_read;
    assign bus.EX_RegWrite_o  = ex_q.reg_write;
    assign bus.MEM_MemRead_o  = mem_q.mem_read;
    assign bus.MEM_MemWrite_o = mem_q.mem_write;
    assign bus.MEM_RegWrite_o = mem_q.reg_write;
    assign bus.WB_RegWrite_o  = wb_q.reg_write;
    assign bus.WB_MemtoReg_o  = wb_q.mem_to_reg;
endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the single-cycle main decoder in the 5-stage MIPS core.
- Decodes the ID-stage opcode into a control bundle and carries that bundle through its own ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use and branch-operand hazards, stalls PC and IF/ID for a parametrised number of cycles, and inserts bubbles.
- Resolves beq/j in ID and drives PC select and IF flush.

Parameters:
- ADDR_W, 5, register-address width of the Rs/Rt/Rd compare inputs.
- LOAD_STALL, 1, bubble cycles per load-use hazard (legal 1..3; a value above 1 models multi-cycle data memory).

Ports:
- clk_i  in  1  core clock, all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- Op_i  in  6  opcode of the instruction in IF/ID.
- IFID_Rs_i  in  ADDR_W  rs field of the IF/ID instruction.
- IFID_Rt_i  in  ADDR_W  rt field of the IF/ID instruction.
- IDEX_Rt_i  in  ADDR_W  rt field held in ID/EX.
- IDEX_Rd_i  in  ADDR_W  rd field held in ID/EX.
- Equal_i  in  1  ID-stage register compare, rs==rt.
- PCWrite_o  out  1  PC load enable.
- IFIDWrite_o  out  1  IF/ID load enable.
- IFFlush_o  out  1  zero IF/ID next cycle.
- PCSrc_o  out  2  PC select: 00 = pc+4, 01 = branch target, 10 = jump target.
- EX_RegDst_o, EX_ALUSrc_o  out  1 each  ID/EX register copies.
- EX_ALUOp_o  out  2  ID/EX register copy.
- EX_MemRead_o  out  1  ID/EX register copy, exported for forwarding.
- EX_RegWrite_o  out  1  ID/EX register copy, exported for forwarding.
- MEM_MemRead_o, MEM_MemWrite_o, MEM_RegWrite_o  out  1 each  EX/MEM register copies.
- WB_RegWrite_o, WB_MemtoReg_o  out  1 each  MEM/WB register copies.

Behaviour:
- Decode (combinational, ID stage), fields listed as RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp:
  - R-type 000000 = 1,0,0,1,0,0,0,0,10
  - addi 001000 = 0,1,0,1,0,0,0,0,00
  - lw 100011 = 0,1,1,1,1,0,0,0,00
  - sw 101011 = 0,1,0,0,0,1,0,0,00
  - beq 000100 = 0,0,0,0,0,0,1,0,01
  - j 000010 = 0,0,0,0,0,0,0,1,00
  - Any other opcode decodes to the all-zero bundle (NOP). No X outputs, no latches.
- Source-use flags:
  - usesRs = R-type, addi, lw, sw, beq.
  - usesRt = R-type, sw, beq.
- Hazard detection (combinational):
  - loadUse = EX_MemRead_o & IDEX_Rt_i!=0 & ((usesRs & IDEX_Rt_i==IFID_Rs_i) | (usesRt & IDEX_Rt_i==IFID_Rt_i)).
  - brHaz = Branch & EX_RegWrite_o & dest!=0 & (dest==IFID_Rs_i | dest==IFID_Rt_i), where dest = EX_RegDst_o ? IDEX_Rd_i : IDEX_Rt_i.
- Stall counter cnt, 2 bits:
  - stall = loadUse | brHaz | (cnt!=0).
  - On loadUse with cnt==0: cnt <= LOAD_STALL-1.
  - While cnt!=0: cnt decrements by 1 each cycle.
  - brHaz alone stalls exactly one cycle per detection.
- While stall is active:
  - PCWrite_o=0, IFIDWrite_o=0.
  - ID/EX loads the all-zero bubble.
  - PCSrc_o=00, IFFlush_o=0; the branch/jump is suppressed until operands are ready.
- EX/MEM and MEM/WB always advance and never stall: EX/MEM <= ID/EX, MEM/WB <= EX/MEM every cycle.
- When not stalling:
  - PCWrite_o=1, IFIDWrite_o=1, ID/EX <= decoded bundle.
  - Jump: PCSrc_o=10, IFFlush_o=1.
  - Branch & Equal_i: PCSrc_o=01, IFFlush_o=1.
  - Otherwise PCSrc_o=00, IFFlush_o=0.
- Jump and Branch are mutually exclusive by decode.
- Reset (rst_i=1 at an edge): all pipeline control registers and cnt cleared to 0, so every EX_/MEM_/WB_ output is 0 the following cycle.
  - Combinational outputs follow the decode of the current inputs, with cnt=0.
  - Reset mid-stall aborts the stall and drops any pending bubbles.
- Latency: a control bundle appears on EX_ 1 cycle after decode, on MEM_ after 2 cycles, on WB_ after 3 cycles.

Optional Feature:
- Macro: CTRL_EXT_OPS_EN.
- Defined:
  - Adds bne 000101 = beq bundle, taken when Equal_i==0; included in Branch for brHaz.
  - Adds ori 001101 = addi bundle with ALUOp 11 (OR); usesRs only.
- Undefined: 000101 and 001101 decode as NOP, and ALUOp 11 is never produced.

Test Plan:
- Reset: rst_i=1 with Op_i=R-type, clock -> all EX_/MEM_/WB_ outputs 0, cnt 0. Deassert reset -> R-type bundle (RegDst=1, RegWrite=1, ALUOp=10) appears on EX_ 1 cycle later, MEM_ after 2, WB_ after 3.
- Load-use, LOAD_STALL=1: lw into $8, then add using $8 as rs -> exactly 1 cycle with PCWrite_o=0 and IFIDWrite_o=0, EX_ outputs all 0 that cycle, add bundle enters ID/EX next cycle. Same sequence with rs=$0 -> no stall.
- LOAD_STALL=3, same load-use sequence -> 3 consecutive stall cycles, 3 bubbles on EX_. Assert rst_i in the 2nd stall cycle -> PCWrite_o=1 the cycle after reset.
- beq with Equal_i=1, no hazard -> PCSrc_o=01 and IFFlush_o=1 for 1 cycle. Equal_i=0 -> PCSrc_o=00. Op_i=j -> PCSrc_o=10, IFFlush_o=1.
- addi $9 in EX, beq reading $9 in ID -> 1 stall cycle with PCSrc_o held at 00, then branch resolves on Equal_i. Unknown opcode 111111 -> all-zero bundle, no stall.
- CTRL_EXT_OPS_EN build: bne with Equal_i=0 -> PCSrc_o=01. ori -> EX_ALUOp_o=11, EX_ALUSrc_o=1, EX_RegWrite_o=1. Build without the macro -> both opcodes decode as NOP.
